// File: rtl/eg2000_pkg.sv
// Shared types and constants for the EG2000 PS/2 keyboard path.
// Event layout, prefix bytes and frame-state encoding.
package eg2000_pkg;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_st_e;

  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Small event queue between the prefix decoder and the consumer.
// Extra pointer bit distinguishes full from empty.
module ps2_fifo
  import eg2000_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  ps2_event_t wdata,
  input  logic       pop,
  output ps2_event_t rdata,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PONE = (AW+1)'(1);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push;
  logic        do_pop;
  ps2_event_t  mem_q [DEPTH];

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) &&
            (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop   = pop & ~empty;
    // a full queue still takes a write when the head leaves this cycle
    do_push  = push & (~full | do_pop);
    overflow = push & full & ~do_pop;
    wptr_d = do_push ? wptr_q + PONE : wptr_q;
    rptr_d = do_pop  ? rptr_q + PONE : rptr_q;
    rdata  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-side receiver: sync/filter, frame FSM,
// E0/F0 prefix folding and an event FIFO.
module ps2_receiver
  import eg2000_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 35468,
  parameter int DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2Dq,
  input  logic       codeReady,
  output logic       codeValid,
  output logic [7:0] code,
  output logic       codeExt,
  output logic       codeRel,
  output logic       error,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FLAST = FW'(FILTER - 1);
  localparam logic [FW-1:0] FONE  = FW'(1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TONE  = TW'(1);

  logic [1:0]    ck_s_q, ck_s_d;
  logic [1:0]    dq_s_q, dq_s_d;
  logic [FW-1:0] ck_n_q, ck_n_d;
  logic [FW-1:0] dq_n_q, dq_n_d;
  logic          ck_f_q, ck_f_d;
  logic          dq_f_q, dq_f_d;
  logic          ck_p_q;
  logic          fall;

  always_comb begin
    ck_s_d = {ck_s_q[0], ps2Ck};
    dq_s_d = {dq_s_q[0], ps2Dq};
    ck_n_d = '0;
    ck_f_d = ck_f_q;
    if (ck_s_q[1] != ck_f_q) begin
      if (ck_n_q == FLAST) ck_f_d = ck_s_q[1];
      else ck_n_d = ck_n_q + FONE;
    end
    dq_n_d = '0;
    dq_f_d = dq_f_q;
    if (dq_s_q[1] != dq_f_q) begin
      if (dq_n_q == FLAST) dq_f_d = dq_s_q[1];
      else dq_n_d = dq_n_q + FONE;
    end
    fall = ck_p_q & ~ck_f_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ck_s_q <= 2'b11;
      dq_s_q <= 2'b11;
      ck_n_q <= '0;
      dq_n_q <= '0;
      ck_f_q <= 1'b1;
      dq_f_q <= 1'b1;
      ck_p_q <= 1'b1;
    end else begin
      ck_s_q <= ck_s_d;
      dq_s_q <= dq_s_d;
      ck_n_q <= ck_n_d;
      dq_n_q <= dq_n_d;
      ck_f_q <= ck_f_d;
      dq_f_q <= dq_f_d;
      ck_p_q <= ck_f_q;
    end
  end

  frame_st_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bits_q, bits_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bits_q  <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    par_d   = par_q;
    tmo_d   = tmo_q;
    tmo_hit = (state_q != ST_IDLE) && (tmo_q == TMAX);
    if (tmo_hit) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
    end else begin
      // counter holds clocks elapsed since the last falling edge
      if (state_q != ST_IDLE)
        tmo_d = fall ? TONE : tmo_q + TONE;
      if (fall) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!dq_f_q) begin
              state_d = ST_START;
              tmo_d   = TONE;
            end
          end
          ST_START: begin
            shift_d = {dq_f_q, shift_q[7:1]};
            bits_d  = 3'd1;
            state_d = ST_DATA;
          end
          ST_DATA: begin
            shift_d = {dq_f_q, shift_q[7:1]};
            bits_d  = bits_q + 3'd1;
            if (bits_q == 3'd7) state_d = ST_PARITY;
          end
          ST_PARITY: begin
            par_d   = odd_ok(shift_q, dq_f_q);
            state_d = ST_STOP;
          end
          ST_STOP: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  logic       byte_v_d, byte_v_q;
  logic       ferr_d, ferr_q;
  logic [7:0] byte_q;

  always_comb begin
    byte_v_d = 1'b0;
    ferr_d   = 1'b0;
    if (fall && !tmo_hit && state_q == ST_STOP) begin
      byte_v_d = par_q & dq_f_q;
      ferr_d   = ~(par_q & dq_f_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_v_q <= 1'b0;
      ferr_q   <= 1'b0;
      byte_q   <= '0;
    end else begin
      byte_v_q <= byte_v_d;
      ferr_q   <= ferr_d;
      byte_q   <= shift_q;
    end
  end

  logic       ext_q, ext_d;
  logic       rel_q, rel_d;
  logic       ev_push;
  ps2_event_t ev;

  always_comb begin
    ext_d   = ext_q;
    rel_d   = rel_q;
    ev_push = 1'b0;
    ev      = '{ext: ext_q, rel: rel_q, code: byte_q};
    if (byte_v_q) begin
      unique case (1'b1)
        (byte_q == PS2_EXT): ext_d = 1'b1;
        (byte_q == PS2_REL): rel_d = 1'b1;
        default: begin
          ev_push = 1'b1;
          ext_d   = 1'b0;
          rel_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      rel_q <= rel_d;
    end
  end

  ps2_event_t head;
  logic       f_full;
  logic       f_empty;
  logic       f_ovf;
  logic       ovf_q, ovf_d;

  ps2_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (ev_push),
    .wdata    (ev),
    .pop      (codeReady),
    .rdata    (head),
    .full     (f_full),
    .empty    (f_empty),
    .overflow (f_ovf)
  );

  assign ovf_d = f_ovf & f_full;

  always_ff @(posedge clock) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign codeValid = ~f_empty;
  assign code      = head.code;
  assign codeExt   = head.ext;
  assign codeRel   = head.rel;
  assign error     = ferr_q | tmo_hit;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: vector table, corner sequences
// and random frames against a queue-based reference model.
module tb_ps2_receiver;

  localparam int FILTER  = 4;
  localparam int TIMEOUT = 300;
  localparam int DEPTH   = 4;
  localparam int H       = 25;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Ck = 1'b1;
  logic       ps2Dq = 1'b1;
  logic       codeReady = 1'b0;
  logic       codeValid;
  logic [7:0] code;
  logic       codeExt;
  logic       codeRel;
  logic       error;
  logic       overflow;

  always #5 clock = ~clock;

  ps2_receiver #(
    .FILTER(FILTER), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2Ck     (ps2Ck),
    .ps2Dq     (ps2Dq),
    .codeReady (codeReady),
    .codeValid (codeValid),
    .code      (code),
    .codeExt   (codeExt),
    .codeRel   (codeRel),
    .error     (error),
    .overflow  (overflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  int   cyc = 0;
  int   err_cnt = 0;
  int   ovf_cnt = 0;
  int   err_cyc = -1;
  int   vld_cyc = -1;
  int   drv_cyc = 0;
  logic vld_prev = 1'b0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (overflow) ovf_cnt++;
    if (codeValid && !vld_prev) vld_cyc = cyc;
    vld_prev = codeValid;
  end

  task automatic ps2_bit(input logic b);
    ps2Dq = b;
    repeat (H) @(negedge clock);
    ps2Ck = 1'b0;
    drv_cyc = cyc;
    repeat (H) @(negedge clock);
    ps2Ck = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b,
                           input bit good, input int n);
    logic [10:0] fr;
    fr = {1'b1, good ? ~^b : ^b, b, 1'b0};
    for (int i = 0; i < n; i++) ps2_bit(fr[i]);
    repeat (H) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit good);
    send_bits(b, good, 11);
  endtask

  task automatic pop_one();
    @(negedge clock);
    codeReady = 1'b1;
    @(negedge clock);
    codeReady = 1'b0;
  endtask

  logic [9:0] mq[$];
  logic       m_ext = 1'b0;
  logic       m_rel = 1'b0;
  int         m_ovf = 0;
  int         m_err = 0;

  task automatic model_frame(input logic [7:0] b,
                             input bit good);
    if (!good) m_err++;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_rel, b});
      else m_ovf++;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] b;
    bit         good;
    bit         q;
    logic [7:0] c;
    bit         ext;
    bit         rel;
    bit         err;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int e0;
    int o0;
    int me;
    int mo;
    int n;
    logic [7:0] rb;
    bit rg;
    logic [9:0] exp;

    tbl[0]  = '{8'h1C, 1, 1, 8'h1C, 0, 0, 0};
    tbl[1]  = '{8'hE0, 1, 0, 8'h00, 0, 0, 0};
    tbl[2]  = '{8'hF0, 1, 0, 8'h00, 0, 0, 0};
    tbl[3]  = '{8'h75, 1, 1, 8'h75, 1, 1, 0};
    tbl[4]  = '{8'h1C, 1, 1, 8'h1C, 0, 0, 0};
    tbl[5]  = '{8'h1C, 0, 0, 8'h00, 0, 0, 1};
    tbl[6]  = '{8'h32, 1, 1, 8'h32, 0, 0, 0};
    tbl[7]  = '{8'hF0, 1, 0, 8'h00, 0, 0, 0};
    tbl[8]  = '{8'h1C, 0, 0, 8'h00, 0, 0, 1};
    tbl[9]  = '{8'h1C, 1, 1, 8'h1C, 0, 1, 0};
    tbl[10] = '{8'hE0, 1, 0, 8'h00, 0, 0, 0};
    tbl[11] = '{8'hE1, 1, 1, 8'hE1, 1, 0, 0};
    tbl[12] = '{8'hAA, 1, 1, 8'hAA, 0, 0, 0};
    tbl[13] = '{8'hFA, 1, 1, 8'hFA, 0, 0, 0};

    repeat (3) @(negedge clock);
    chk("rst_valid", codeValid, 0);
    chk("rst_code", code, 0);
    chk("rst_flags", {codeExt, codeRel}, 0);
    chk("rst_pulses", {error, overflow}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    for (int i = 0; i < 14; i++) begin
      e0 = err_cnt;
      err_cyc = -1;
      vld_cyc = -1;
      send_frame(tbl[i].b, tbl[i].good);
      chk($sformatf("t%0d_err", i), err_cnt - e0, tbl[i].err);
      if (!tbl[i].good)
        chk($sformatf("t%0d_errlat", i),
            err_cyc - drv_cyc, FILTER + 3);
      if (tbl[i].q) begin
        chk($sformatf("t%0d_vldlat", i),
            vld_cyc - drv_cyc, FILTER + 4);
        chk($sformatf("t%0d_valid", i), codeValid, 1);
        chk($sformatf("t%0d_code", i), code, tbl[i].c);
        chk($sformatf("t%0d_ext", i), codeExt, tbl[i].ext);
        chk($sformatf("t%0d_rel", i), codeRel, tbl[i].rel);
        pop_one();
      end
      chk($sformatf("t%0d_empty", i), codeValid, 0);
    end

    // stall mid-frame: prefix flag survives the timeout
    send_frame(8'hE0, 1);
    e0 = err_cnt;
    send_bits(8'h29, 1, 5);
    repeat (TIMEOUT + 50) @(negedge clock);
    chk("tmo_err", err_cnt - e0, 1);
    chk("tmo_lat", err_cyc - drv_cyc, FILTER + 2 + TIMEOUT);
    chk("tmo_empty", codeValid, 0);
    send_frame(8'h29, 1);
    chk("tmo_next_v", codeValid, 1);
    chk("tmo_next", {codeExt, codeRel, code}, {2'b10, 8'h29});
    pop_one();

    // overflow: six events into four slots, then drain
    o0 = ovf_cnt;
    for (int i = 1; i <= 6; i++)
      send_frame(8'(i), 1);
    chk("ovf_cnt", ovf_cnt - o0, 2);
    @(negedge clock);
    codeReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d_v", i), codeValid, 1);
      chk($sformatf("drain%0d", i), code, i);
      @(negedge clock);
    end
    codeReady = 1'b0;
    chk("drain_empty", codeValid, 0);

    // reset in the middle of a frame
    send_frame(8'h11, 1);
    send_frame(8'hE0, 1);
    send_bits(8'h5A, 1, 6);
    e0 = err_cnt;
    reset = 1'b1;
    @(negedge clock);
    chk("mrst_valid", codeValid, 0);
    chk("mrst_outs",
        {code, codeExt, codeRel, error, overflow}, 0);
    reset = 1'b0;
    repeat (TIMEOUT + 50) @(negedge clock);
    chk("mrst_noerr", err_cnt - e0, 0);
    send_frame(8'h5A, 1);
    chk("mrst_next_v", codeValid, 1);
    chk("mrst_next", {codeExt, codeRel, code}, {2'b00, 8'h5A});
    pop_one();

    // random frames against the model
    m_ext = 1'b0;
    m_rel = 1'b0;
    for (int g = 0; g < 5; g++) begin
      n  = $urandom_range(1, 6);
      o0 = ovf_cnt;
      e0 = err_cnt;
      mo = m_ovf;
      me = m_err;
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 9))
          0, 1:    rb = 8'hE0;
          2, 3:    rb = 8'hF0;
          default: rb = 8'($urandom_range(0, 255));
        endcase
        rg = ($urandom_range(0, 7) != 0);
        send_frame(rb, rg);
        model_frame(rb, rg);
      end
      chk($sformatf("g%0d_ovf", g), ovf_cnt - o0, m_ovf - mo);
      chk($sformatf("g%0d_err", g), err_cnt - e0, m_err - me);
      @(negedge clock);
      codeReady = 1'b1;
      while (mq.size() > 0) begin
        exp = mq.pop_front();
        chk($sformatf("g%0d_v", g), codeValid, 1);
        chk($sformatf("g%0d_ev", g),
            {codeExt, codeRel, code}, exp);
        @(negedge clock);
      end
      codeReady = 1'b0;
      chk($sformatf("g%0d_empty", g), codeValid, 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
